alarm_zone_ctrl: RTL
====================

# alarm_zone_ctrl

Multi-zone, parametrised successor to the single-input alarm state machine in the alarm tile. Watches NUM_ZONES sensor inputs with per-zone bypass and instant/delayed zone types, runs a programmable entry delay, checks a disarm code with lockout on repeated failures, and auto-silences the siren after a timeout. Sits between the tile's input-pin decode and the uo_out LED/siren drivers.

## Interface

Parameters:
- NUM_ZONES, 4: number of sensor zones (1-8).
- CODE_W, 4: disarm code width.
- ENTRY_DELAY, 8: cycles from delayed-zone trip to ALARM_ON (>=1).
- SIREN_TIMEOUT, 16: cycles siren stays on before auto-rearm (>=1).
- MAX_TRIES, 3: consecutive wrong codes before lockout (>=1).
- LOCKOUT, 32: cycles codes are ignored after lockout starts (>=1).
- INSTANT_MASK, 4'b0001: zones that skip the entry delay (NUM_ZONES bits).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- ena  in  1  tile enable; low freezes all state, counters and outputs.
- arm  in  1  single-cycle arm request.
- code_valid  in  1  single-cycle strobe qualifying code_in.
- code_in  in  CODE_W  entered disarm code.
- cfg_code  in  CODE_W  stored correct code (static).
- zone_in  in  NUM_ZONES  sensor levels, 1 = tripped; synchronous to clk (synchronised upstream).
- zone_bypass  in  NUM_ZONES  1 = zone ignored.
- state  out  2  OFF=00, ARMED=01, TRIGGERED=10, ALARM_ON=11.
- siren  out  1  high only in ALARM_ON.
- zone_latched  out  NUM_ZONES  zones that caused the current event.
- arm_fail  out  1  one-cycle pulse: arm refused.
- locked  out  1  high during code lockout.

## Operation

- active = zone_in & ~zone_bypass.
- OFF: arm with active==0 -> ARMED, zone_latched cleared. arm with active!=0 -> stay OFF, arm_fail pulse. code_valid ignored.
- ARMED: active!=0 -> zone_latched |= active; if (active & INSTANT_MASK)!=0 -> ALARM_ON, else TRIGGERED with delay counter loaded ENTRY_DELAY-1. Correct code -> OFF.
- TRIGGERED: further active zones OR into zone_latched. Correct code -> OFF. Counter==0 -> ALARM_ON, else decrement. Instant zone trip -> ALARM_ON immediately.
- ALARM_ON: siren counter loaded SIREN_TIMEOUT-1 on entry; correct code -> OFF; counter==0 -> ARMED (siren off, zone_latched retained); new trips keep ORing into zone_latched.
- Code check (when code_valid, not locked, state!=OFF): equal -> accept, fail count cleared. Unequal -> fail count +1; reaching MAX_TRIES -> locked=1, lockout counter loaded LOCKOUT-1, fail count cleared; in TRIGGERED this also forces ALARM_ON.
- locked: code_valid ignored; counter==0 -> locked=0 next cycle.
- Entering OFF clears fail count; lockout continues to expire independently.
- arm outside OFF ignored.
- Priority in one cycle: accepted code > lockout-forced alarm > instant trip > delay/siren expiry > delayed trip.
- ena=0: no state, counter, latch or output change; pending strobes that cycle are dropped.

## Timing

- All outputs registered; input sampled at edge N is reflected on outputs after edge N (1-cycle latency).
- Reset (rst_n=0, async): state=OFF, siren=0, zone_latched=0, arm_fail=0, locked=0, all counters and fail count 0. Reset mid-alarm ends it immediately.
- Delayed trip at edge N: TRIGGERED after N, ALARM_ON after edge N+ENTRY_DELAY (absent disarm).
- ALARM_ON entered at edge M: ARMED after edge M+SIREN_TIMEOUT.
- Lockout starting at edge L: locked high after L through edge L+LOCKOUT, code accepted again from edge L+LOCKOUT+1.
- arm_fail high exactly one cycle.
- Counter widths: $clog2 of max(value,2); no wrap — counters saturate at 0.

## Test plan

- Reset, arm with zone_in=0 -> state 01 next cycle; arm with zone_in[2]=1, bypass=0 -> state 00, arm_fail one-cycle pulse; same with zone_bypass[2]=1 -> state 01.
- ARMED, trip zone 1 (delayed), ENTRY_DELAY=8 -> state 10 for 8 cycles then 11, siren=1, zone_latched=0010; correct code at cycle 5 instead -> state 00, siren never high.
- ARMED, trip zone 0 (instant) -> state 11 next cycle, zone_latched=0001; no code -> after 16 cycles state 01, siren 0, zone_latched still 0001.
- TRIGGERED, three wrong codes -> state 11 and locked=1 after third; correct code during lockout ignored; after 32 cycles locked=0, correct code -> state 00.
- Same-cycle correct code and instant trip in ARMED -> state 00; ena=0 for 5 cycles in TRIGGERED -> counter frozen, ALARM_ON delayed by 5 cycles.
- Assert rst_n low asynchronously mid-ALARM_ON (between edges) -> siren=0, state=00 without waiting for clk.

Source files
------------

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone alarm controller: bypassable instant/delayed zones, entry delay, code disarm with lockout, siren timeout.
// Latency: every output is registered; inputs sampled at an edge show up on the outputs right after that edge.
// Backpressure: none; ena=0 freezes the block and drops any arm/code strobe presented in that cycle.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   ena              tile enable; low holds every register
//   arm              single-cycle arm request (only honoured in OFF)
//   code_valid       single-cycle strobe qualifying code_in
//   code_in          entered disarm code
//   cfg_code         stored correct code (static)
//   zone_in          sensor levels, 1 = tripped
//   zone_bypass      1 = zone ignored
//   state            OFF=00, ARMED=01, TRIGGERED=10, ALARM_ON=11
//   siren            high only in ALARM_ON
//   zone_latched     zones that caused the current event
//   arm_fail         one-cycle pulse when an arm request is refused
//   locked           high while code entry is locked out
module alarm_zone_ctrl #(
   parameter int                   NUM_ZONES     = 4,
   parameter int                   CODE_W        = 4,
   parameter int                   ENTRY_DELAY   = 8,
   parameter int                   SIREN_TIMEOUT = 16,
   parameter int                   MAX_TRIES     = 3,
   parameter int                   LOCKOUT       = 32,
   parameter logic [NUM_ZONES-1:0] INSTANT_MASK  = 4'b0001
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 arm,
   input  logic                 code_valid,
   input  logic [CODE_W-1:0]    code_in,
   input  logic [CODE_W-1:0]    cfg_code,
   input  logic [NUM_ZONES-1:0] zone_in,
   input  logic [NUM_ZONES-1:0] zone_bypass,
   output logic [1:0]           state,
   output logic                 siren,
   output logic [NUM_ZONES-1:0] zone_latched,
   output logic                 arm_fail,
   output logic                 locked
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_ARMED = 2'b01,
      ST_TRIG  = 2'b10,
      ST_ALARM = 2'b11
   } state_t;

   // Counters are sized to hold their load value (value-1), minimum one bit.
   localparam int DLY_W  = $clog2((ENTRY_DELAY   > 2) ? ENTRY_DELAY   : 2);
   localparam int SIR_W  = $clog2((SIREN_TIMEOUT > 2) ? SIREN_TIMEOUT : 2);
   localparam int LCK_W  = $clog2((LOCKOUT       > 2) ? LOCKOUT       : 2);
   localparam int FAIL_W = $clog2((MAX_TRIES     > 2) ? MAX_TRIES     : 2);

   localparam logic [DLY_W-1:0]  DLY_LD   = DLY_W'(ENTRY_DELAY - 1);
   localparam logic [SIR_W-1:0]  SIR_LD   = SIR_W'(SIREN_TIMEOUT - 1);
   localparam logic [LCK_W-1:0]  LCK_LD   = LCK_W'(LOCKOUT - 1);
   localparam logic [FAIL_W-1:0] FAIL_TOP = FAIL_W'(MAX_TRIES - 1);

   state_t              st;
   logic [DLY_W-1:0]    dly_cnt;
   logic [SIR_W-1:0]    sir_cnt;
   logic [LCK_W-1:0]    lck_cnt;
   logic [FAIL_W-1:0]   fail_cnt;

   logic [NUM_ZONES-1:0] active;
   logic                 any_trip;
   logic                 instant_trip;
   logic                 code_live;
   logic                 code_ok;
   logic                 code_bad;
   logic                 lock_start;

   assign active       = zone_in & ~zone_bypass;
   assign any_trip     = |active;
   assign instant_trip = |(active & INSTANT_MASK);

   // Codes are only looked at while the system is armed in some form and not locked out.
   assign code_live  = code_valid & ~locked & (st != ST_OFF);
   assign code_ok    = code_live & (code_in == cfg_code);
   assign code_bad   = code_live & (code_in != cfg_code);
   // The wrong code that brings the run of failures up to MAX_TRIES starts the lockout.
   assign lock_start = code_bad & (fail_cnt == FAIL_TOP);

   assign state = st;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st           <= ST_OFF;
         siren        <= 1'b0;
         zone_latched <= '0;
         arm_fail     <= 1'b0;
         locked       <= 1'b0;
         dly_cnt      <= '0;
         sir_cnt      <= '0;
         lck_cnt      <= '0;
         fail_cnt     <= '0;
      end else if (ena) begin
         arm_fail <= 1'b0;

         // Lockout timer runs on its own, in every state including OFF.
         if (locked) begin
            if (lck_cnt == '0) begin
               locked <= 1'b0;
            end else begin
               lck_cnt <= lck_cnt - LCK_W'(1);
            end
         end
         if (lock_start) begin
            locked  <= 1'b1;
            lck_cnt <= LCK_LD;
         end

         // Consecutive-failure tracking; cleared on a good code or when a lockout begins.
         if (code_ok) begin
            fail_cnt <= '0;
         end else if (code_bad) begin
            fail_cnt <= lock_start ? '0 : fail_cnt + FAIL_W'(1);
         end

         unique case (st)
            ST_OFF: begin
               if (arm) begin
                  if (!any_trip) begin
                     st           <= ST_ARMED;
                     zone_latched <= '0;
                  end else begin
                     arm_fail <= 1'b1;
                  end
               end
            end

            ST_ARMED: begin
               if (code_ok) begin
                  st <= ST_OFF;
               end else if (any_trip) begin
                  zone_latched <= zone_latched | active;
                  if (instant_trip) begin
                     st      <= ST_ALARM;
                     siren   <= 1'b1;
                     sir_cnt <= SIR_LD;
                  end else begin
                     st      <= ST_TRIG;
                     dly_cnt <= DLY_LD;
                  end
               end
            end

            ST_TRIG: begin
               if (code_ok) begin
                  st <= ST_OFF;
               end else begin
                  zone_latched <= zone_latched | active;
                  // Lockout, instant trip and delay expiry all end the entry delay the same way.
                  if (lock_start || instant_trip || (dly_cnt == '0)) begin
                     st      <= ST_ALARM;
                     siren   <= 1'b1;
                     sir_cnt <= SIR_LD;
                  end else begin
                     dly_cnt <= dly_cnt - DLY_W'(1);
                  end
               end
            end

            ST_ALARM: begin
               if (code_ok) begin
                  st    <= ST_OFF;
                  siren <= 1'b0;
               end else begin
                  zone_latched <= zone_latched | active;
                  // Auto-rearm keeps zone_latched so the cause stays visible.
                  if (sir_cnt == '0) begin
                     st    <= ST_ARMED;
                     siren <= 1'b0;
                  end else begin
                     sir_cnt <= sir_cnt - SIR_W'(1);
                  end
               end
            end

            default: begin
               st    <= ST_OFF;
               siren <= 1'b0;
            end
         endcase
      end
   end

endmodule
